// File: rtl/lcd_screen_scheduler.sv
// Frame-synchronous round-robin owner of the LCD screen among three requesters; decisions on vsync fall.
// Optional blink phase generator is built only when LCD_SCHED_BLINK_EN is defined.
module lcd_screen_scheduler #(
   parameter logic [7:0] HOLD_FRAMES    = 8'd60,
   parameter logic [2:0] DEFAULT_SCREEN = 3'd0,
   parameter logic [7:0] BLINK_FRAMES   = 8'd30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync,
   input  logic [2:0] req,
   input  logic [8:0] screen_id,
   output logic [2:0] grant,
   output logic [2:0] screen_sel,
   output logic       busy,
   output logic       blink
);

   typedef enum logic {S_IDLE, S_HOLD} state_t;

   state_t     r_state;
   logic [2:0] r_grant;
   logic [2:0] r_screen_sel;
   logic       r_busy;
   logic [1:0] r_last;
   logic [7:0] r_frame_cnt;
   logic       r_vsync_d;
   logic       r_armed;

   logic       w_frame_tick;
   logic [2:0] w_idle_pick;
   logic [2:0] w_oth_pick;
   logic       w_idle_hit;
   logic [1:0] w_idle_idx;
   logic       w_oth_hit;
   logic [1:0] w_oth_idx;
   logic       w_own_req;
   logic       w_expired;

   if (HOLD_FRAMES == 8'd0 || BLINK_FRAMES == 8'd0) begin : g_illegal_params
      $error("lcd_screen_scheduler: HOLD_FRAMES and BLINK_FRAMES must be 1..255");
   end

   function automatic logic [1:0] nxt3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   // Returns {hit, index}, searching last+1, last+2, last (mod 3).
   function automatic logic [2:0] pick(input logic [1:0] last, input logic [2:0] mask);
      logic [1:0] c1;
      logic [1:0] c2;
      c1 = nxt3(last);
      c2 = nxt3(c1);
      if (mask[c1])
         return {1'b1, c1};
      else if (mask[c2])
         return {1'b1, c2};
      else if (mask[last])
         return {1'b1, last};
      else
         return 3'b000;
   endfunction

   function automatic logic [2:0] sel_of(input logic [8:0] ids, input logic [1:0] idx);
      case (idx)
         2'd1:    return ids[5:3];
         2'd2:    return ids[8:6];
         default: return ids[2:0];
      endcase
   endfunction

   // r_armed keeps the reset value of r_vsync_d from faking a tick when vsync is already low.
   assign w_frame_tick = r_vsync_d & ~vsync & r_armed;

   assign w_idle_pick = pick(r_last, req);
   assign w_oth_pick  = pick(r_last, req & ~r_grant);
   assign w_idle_hit  = w_idle_pick[2];
   assign w_idle_idx  = w_idle_pick[1:0];
   assign w_oth_hit   = w_oth_pick[2];
   assign w_oth_idx   = w_oth_pick[1:0];
   assign w_own_req   = req[r_last];
   assign w_expired   = (r_frame_cnt == HOLD_FRAMES - 8'd1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_grant      <= 3'b000;
         r_busy       <= 1'b0;
         r_screen_sel <= DEFAULT_SCREEN;
         r_frame_cnt  <= 8'd0;
         r_last       <= 2'd2;
         r_vsync_d    <= 1'b1;
         r_armed      <= 1'b0;
      end else begin
         r_vsync_d <= vsync;
         if (vsync)
            r_armed <= 1'b1;
         if (w_frame_tick) begin
            case (r_state)
               S_IDLE: begin
                  if (w_idle_hit) begin
                     r_state      <= S_HOLD;
                     r_grant      <= 3'b001 << w_idle_idx;
                     r_screen_sel <= sel_of(screen_id, w_idle_idx);
                     r_last       <= w_idle_idx;
                     r_frame_cnt  <= 8'd0;
                     r_busy       <= 1'b1;
                  end
               end
               S_HOLD: begin
                  if (!w_own_req || (w_expired && w_oth_hit)) begin
                     if (w_oth_hit) begin
                        r_grant      <= 3'b001 << w_oth_idx;
                        r_screen_sel <= sel_of(screen_id, w_oth_idx);
                        r_last       <= w_oth_idx;
                        r_frame_cnt  <= 8'd0;
                     end else begin
                        r_state      <= S_IDLE;
                        r_grant      <= 3'b000;
                        r_busy       <= 1'b0;
                        r_screen_sel <= DEFAULT_SCREEN;
                        r_frame_cnt  <= 8'd0;
                     end
                  end else begin
                     if (!w_expired)
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                     r_screen_sel <= sel_of(screen_id, r_last);
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign grant      = r_grant;
   assign screen_sel = r_screen_sel;
   assign busy       = r_busy;

`ifdef LCD_SCHED_BLINK_EN
   logic [7:0] r_blink_cnt;
   logic       r_blink;
   logic       w_own_chg;
   logic       w_hold_tick;

   // Any grant, rotation, drop or return to IDLE restarts the blink phase.
   assign w_own_chg   = w_frame_tick &
                        (((r_state == S_IDLE) && w_idle_hit) ||
                         ((r_state == S_HOLD) && (!w_own_req || (w_expired && w_oth_hit))));
   assign w_hold_tick = w_frame_tick && (r_state == S_HOLD) && w_own_req &&
                        !(w_expired && w_oth_hit);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_blink     <= 1'b0;
         r_blink_cnt <= 8'd0;
      end else if (w_own_chg) begin
         r_blink     <= 1'b0;
         r_blink_cnt <= 8'd0;
      end else if (w_hold_tick) begin
         if (r_blink_cnt == BLINK_FRAMES - 8'd1) begin
            r_blink     <= ~r_blink;
            r_blink_cnt <= 8'd0;
         end else begin
            r_blink_cnt <= r_blink_cnt + 8'd1;
         end
      end
   end

   assign blink = r_blink;
`else
   assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_screen_scheduler.sv
// Bench for lcd_screen_scheduler: table of per-frame vectors with a scoreboard queue, plus
// hand-written sequences for req drop, reset during HOLD and vsync held low.
module tb_lcd_screen_scheduler;

   localparam logic [7:0] HF  = 8'd4;
   localparam logic [7:0] BF  = 8'd2;
   localparam logic [2:0] DEF = 3'd6;
   localparam logic [8:0] S   = {3'd3, 3'd5, 3'd1};
   localparam logic [8:0] S7  = {3'd3, 3'd7, 3'd1};
   localparam logic [8:0] S2  = {3'd2, 3'd4, 3'd6};

   logic       clk = 1'b0;
   logic       rst;
   logic       vsync;
   logic [2:0] req;
   logic [8:0] screen_id;
   logic [2:0] grant;
   logic [2:0] screen_sel;
   logic       busy;
   logic       blink;

   typedef struct {
      logic       rst_before;
      logic [2:0] req;
      logic [8:0] sid;
      logic [2:0] grant;
      logic [2:0] sel;
      logic       busy;
      logic       blink;
   } vec_t;

   typedef struct {
      logic [2:0] grant;
      logic [2:0] sel;
      logic       busy;
      logic       blink;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   lcd_screen_scheduler #(
      .HOLD_FRAMES   (HF),
      .DEFAULT_SCREEN(DEF),
      .BLINK_FRAMES  (BF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .vsync     (vsync),
      .req       (req),
      .screen_id (screen_id),
      .grant     (grant),
      .screen_sel(screen_sel),
      .busy      (busy),
      .blink     (blink)
   );

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic blink_exp(input logic b);
`ifdef LCD_SCHED_BLINK_EN
      return b;
`else
      return 1'b0 & b;
`endif
   endfunction

   task automatic check_outs(input string tag, input exp_t e);
      check({tag, ".grant"}, {6'd0, grant}, {6'd0, e.grant});
      check({tag, ".sel"},   {6'd0, screen_sel}, {6'd0, e.sel});
      check({tag, ".busy"},  {8'd0, busy}, {8'd0, e.busy});
      check({tag, ".blink"}, {8'd0, blink}, {8'd0, blink_exp(e.blink)});
   endtask

   task automatic add(input logic rb, input logic [2:0] r, input logic [8:0] s,
                      input logic [2:0] g, input logic [2:0] sl, input logic b, input logic bl);
      tbl.push_back('{rb, r, s, g, sl, b, bl});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b0;
      vsync = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // One frame: drive inputs with a vsync fall, check the tick result, scramble inputs
   // while vsync is low, then re-check that nothing moved before the next tick.
   task automatic frame(input string tag, input logic [2:0] r, input logic [8:0] s, input exp_t e);
      exp_t x;
      @(negedge clk);
      req       = r;
      screen_id = s;
      vsync     = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      check_outs(tag, x);
      repeat (4) begin
         @(negedge clk);
         req       = 3'($urandom_range(0, 7));
         screen_id = 9'($urandom_range(0, 511));
      end
      @(negedge clk);
      vsync = 1'b1;
      repeat (2) @(negedge clk);
      check_outs({tag, ".between"}, x);
   endtask

   initial begin
      rst       = 1'b0;
      vsync     = 1'b1;
      req       = 3'b000;
      screen_id = 9'd0;

      //  rst  req     sid  grant   sel   busy blink
      add(0, 3'b010, S,  3'b010, 3'd5, 1, 0);
      add(0, 3'b010, S,  3'b010, 3'd5, 1, 0);
      add(0, 3'b010, S7, 3'b010, 3'd7, 1, 1);
      add(0, 3'b011, S,  3'b010, 3'd5, 1, 1);
      add(0, 3'b011, S,  3'b001, 3'd1, 1, 0);
      add(0, 3'b011, S,  3'b001, 3'd1, 1, 0);
      add(0, 3'b011, S,  3'b001, 3'd1, 1, 1);
      add(0, 3'b011, S,  3'b001, 3'd1, 1, 1);
      add(0, 3'b011, S,  3'b010, 3'd5, 1, 0);
      add(0, 3'b111, S,  3'b010, 3'd5, 1, 0);
      add(0, 3'b101, S,  3'b100, 3'd3, 1, 0);
      add(0, 3'b101, S,  3'b100, 3'd3, 1, 0);
      add(0, 3'b001, S,  3'b001, 3'd1, 1, 0);
      add(0, 3'b001, S,  3'b001, 3'd1, 1, 0);
      add(0, 3'b001, S,  3'b001, 3'd1, 1, 1);
      add(0, 3'b001, S,  3'b001, 3'd1, 1, 1);
      add(0, 3'b001, S,  3'b001, 3'd1, 1, 0);
      add(0, 3'b001, S,  3'b001, 3'd1, 1, 0);
      add(0, 3'b101, S,  3'b100, 3'd3, 1, 0);
      add(0, 3'b000, S,  3'b000, DEF,  0, 0);
      add(0, 3'b000, S2, 3'b000, DEF,  0, 0);
      add(1, 3'b011, S,  3'b001, 3'd1, 1, 0);
      add(0, 3'b011, S,  3'b001, 3'd1, 1, 0);
      add(0, 3'b011, S,  3'b001, 3'd1, 1, 1);
      add(0, 3'b011, S,  3'b001, 3'd1, 1, 1);
      add(0, 3'b011, S,  3'b010, 3'd5, 1, 0);
      add(0, 3'b011, S,  3'b010, 3'd5, 1, 0);
      add(0, 3'b011, S,  3'b010, 3'd5, 1, 1);
      add(0, 3'b011, S,  3'b010, 3'd5, 1, 1);
      add(0, 3'b011, S,  3'b001, 3'd1, 1, 0);

      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_outs("reset", '{3'b000, DEF, 1'b0, 1'b0});

      // Requests present but no vsync fall yet: nothing may be granted.
      req       = 3'b010;
      screen_id = S;
      repeat (3) @(negedge clk);
      check_outs("pretick", '{3'b000, DEF, 1'b0, 1'b0});

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst_before)
            do_reset();
         frame($sformatf("vec%0d", i), tbl[i].req, tbl[i].sid,
               '{tbl[i].grant, tbl[i].sel, tbl[i].busy, tbl[i].blink});
      end

      // Owner drops its request: outputs hold until the next tick, then go idle.
      @(negedge clk);
      req       = 3'b000;
      screen_id = S;
      repeat (3) begin
         @(negedge clk);
         check_outs("drop.pre", '{3'b001, 3'd1, 1'b1, 1'b0});
      end
      frame("drop", 3'b000, S, '{3'b000, DEF, 1'b0, 1'b0});

      // Reset during HOLD with vsync low throughout: no grant until a fresh fall.
      frame("rsthold.grant", 3'b100, S, '{3'b100, 3'd3, 1'b1, 1'b0});
      @(negedge clk);
      req       = 3'b100;
      screen_id = S;
      vsync     = 1'b0;
      rst       = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check_outs("rsthold.reset", '{3'b000, DEF, 1'b0, 1'b0});
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         check("rsthold.lowgrant", {6'd0, grant}, 9'd0);
         check("rsthold.lowbusy", {8'd0, busy}, 9'd0);
      end
      vsync = 1'b1;
      repeat (2) @(negedge clk);
      frame("rsthold.regrant", 3'b100, S, '{3'b100, 3'd3, 1'b1, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
